// File: rtl/pixie_pkg.sv
// Shared types and widths for the Pixie framebuffer arbiter.
package pixie_pkg;

  localparam int FB_ADDR_W = 10;
  localparam int FB_DATA_W = 8;

  // One buffered front-end write: target byte address and its data.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

  // Clear sequencer states.
  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

endpackage

// File: rtl/pixie_wr_fifo.sv
// Synchronous write buffer holding fb_wr_t entries between the capture
// front end and the framebuffer RAM. A push into an empty buffer becomes
// visible at the head on the following cycle, never the same cycle.
module pixie_wr_fifo
  import pixie_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push_i,
  input  fb_wr_t wdata_i,
  input  logic   pop_i,
  output fb_wr_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  fb_wr_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + (PW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PW+1)'(1);
  end

  // Pointer and count registers; reset empties the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: storage has no reset; count_q decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixie_fb_arbiter.sv
// Arbitrates the single-port framebuffer RAM between the hard real-time
// display read port, the clear sequencer and the buffered capture writes.
// Priority: read > clear > buffered write > idle (address held).
module pixie_fb_arbiter
  import pixie_pkg::*;
#(
  parameter int                   FB_WORDS    = 1024,
  parameter int                   FIFO_DEPTH  = 4,
  parameter logic [FB_DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rd_en,
  input  logic [FB_ADDR_W-1:0] rd_addr,
  output logic [FB_DATA_W-1:0] rd_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [FB_DATA_W-1:0] wr_data,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic [FB_ADDR_W-1:0] ram_addr,
  output logic                 ram_we,
  output logic [FB_DATA_W-1:0] ram_wdata,
  input  logic [FB_DATA_W-1:0] ram_rdata
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_WORDS - 1);

  clr_state_t           state_q, state_d;
  logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [FB_ADDR_W-1:0] last_addr_q;
  logic                 rd_valid_q;
  logic [FB_DATA_W-1:0] rd_hold_q;

  fb_wr_t fifo_in, fifo_head;
  logic   fifo_full, fifo_empty, fifo_pop;

  assign fifo_in    = '{addr: wr_addr, data: wr_data};
  assign wr_ready   = ~fifo_full;
  assign clear_busy = (state_q == CLR_RUN);
  assign rd_data    = rd_valid_q ? ram_rdata : rd_hold_q;

  pixie_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (wr_valid & wr_ready),
    .wdata_i (fifo_in),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Grant decision, RAM port drive and clear FSM next state.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    fifo_pop  = 1'b0;
    ram_addr  = last_addr_q;
    ram_we    = 1'b0;
    ram_wdata = fifo_head.data;

    if (rd_en) begin
      // A read stalls the clear counter; that address is written next free cycle.
      ram_addr = rd_addr;
    end else if (state_q == CLR_RUN) begin
      ram_addr  = clr_cnt_q;
      ram_we    = 1'b1;
      ram_wdata = CLEAR_VALUE;
      clr_cnt_d = clr_cnt_q + FB_ADDR_W'(1);
      if (clr_cnt_q == LAST_ADDR) state_d = CLR_IDLE;
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      ram_addr  = fifo_head.addr;
      ram_wdata = fifo_head.data;
      ram_we    = 1'b1;
    end

    // A request only starts a clear from idle; a running clear never restarts.
    if (state_q == CLR_IDLE && clear_req) begin
      state_d   = CLR_RUN;
      clr_cnt_d = '0;
    end
  end

  // Clear FSM, held RAM address and read return path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLR_IDLE;
      clr_cnt_q   <= '0;
      last_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      last_addr_q <= ram_addr;
      rd_valid_q  <= rd_en;
      if (rd_valid_q) rd_hold_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_pixie_fb_arbiter.sv
// Self-checking bench for pixie_fb_arbiter with a read-first synchronous
// RAM model and a queue/array reference of accepted writes.
module tb_pixie_fb_arbiter;
  import pixie_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       clear_req;
  logic       clear_busy;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  int vectors    = 0;
  int miscompares = 0;
  int we_count   = 0;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mem [1024];

  always #5 clk = ~clk;

  pixie_fb_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Framebuffer RAM: single port, read-first, one cycle read latency.
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) if (ram_we === 1'b1) we_count++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    rd_en = 1'b0; wr_valid = 1'b0; clear_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; drive_idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    #23;
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    vectors++; if (clear_busy !== 1'b0) begin miscompares++; $display("FAIL reset_clear_busy: got %b want 0", clear_busy); end
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    @(negedge clk); reset_n = 1'b1;
    step();
  endtask

  // T1: one-cycle read latency, then the value is held while RAM output changes.
  task automatic test_read_latency();
    wr_valid = 1'b1; wr_addr = 10'h155; wr_data = 8'hA5; step();
    wr_valid = 1'b0; settle();
    vectors++; if (ram_we !== 1'b1 || ram_addr !== 10'h155) begin miscompares++; $display("FAIL preload_write: got we=%b addr=%h want we=1 addr=155", ram_we, ram_addr); end
    step();
    rd_en = 1'b1; rd_addr = 10'h155;
    wr_valid = 1'b1; wr_addr = 10'h155; wr_data = 8'h3C;
    settle();
    vectors++; if (ram_we !== 1'b0 || ram_addr !== 10'h155) begin miscompares++; $display("FAIL read_grant: got we=%b addr=%h want we=0 addr=155", ram_we, ram_addr); end
    step();
    rd_en = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      vectors++; if (rd_data !== 8'hA5) begin miscompares++; $display("FAIL read_hold[%0d]: got %h want a5", i, rd_data); end
      step();
    end
  endtask

  // T2: a read steals the first pop cycle; buffered writes then land in order.
  task automatic test_read_priority();
    wr_t e [3];
    logic [9:0] ra;
    for (int i = 0; i < 3; i++) begin
      e[i].a = 10'($urandom_range(1023)); e[i].d = 8'($urandom);
    end
    ra = 10'($urandom_range(1023));
    wr_valid = 1'b1; wr_addr = e[0].a; wr_data = e[0].d; settle();
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL push_no_bypass: got we=%b want 0", ram_we); end
    step();
    wr_addr = e[1].a; wr_data = e[1].d; rd_en = 1'b1; rd_addr = ra; settle();
    vectors++; if (ram_we !== 1'b0 || ram_addr !== ra) begin miscompares++; $display("FAIL prio_read: got we=%b addr=%h want we=0 addr=%h", ram_we, ram_addr, ra); end
    step();
    wr_addr = e[2].a; wr_data = e[2].d; rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      vectors++;
      if (ram_we !== 1'b1 || ram_addr !== e[i].a || ram_wdata !== e[i].d) begin
        miscompares++;
        $display("FAIL prio_write[%0d]: got we=%b %h/%h want we=1 %h/%h", i, ram_we, ram_addr, ram_wdata, e[i].a, e[i].d);
      end
      step();
      wr_valid = 1'b0;
    end
    settle();
    vectors++; if (ram_we !== 1'b0 || ram_addr !== e[2].a) begin miscompares++; $display("FAIL idle_addr_hold: got we=%b addr=%h want we=0 addr=%h", ram_we, ram_addr, e[2].a); end
    step();
  endtask

  // T3: buffer fills behind a continuous read, then drains in order.
  task automatic test_fifo_full();
    wr_t f [5];
    int  occ;
    bit  exp_ready;
    for (int i = 0; i < 5; i++) begin
      f[i].a = 10'($urandom_range(1023)); f[i].d = 8'($urandom);
    end
    rd_en = 1'b1; rd_addr = 10'h000;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_addr = f[k].a; wr_data = f[k].d; settle();
      vectors++; if (wr_ready !== 1'b1 || ram_we !== 1'b0) begin miscompares++; $display("FAIL fill[%0d]: got ready=%b we=%b want ready=1 we=0", k, wr_ready, ram_we); end
      step();
    end
    wr_addr = f[4].a; wr_data = f[4].d;
    for (int k = 0; k < 2; k++) begin
      settle();
      vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL full_hold[%0d]: got ready=%b want 0", k, wr_ready); end
      step();
    end
    rd_en = 1'b0; occ = 4;
    for (int i = 0; i < 5; i++) begin
      settle();
      exp_ready = (occ != 4);
      vectors++; if (wr_ready !== exp_ready) begin miscompares++; $display("FAIL drain_ready[%0d]: got %b want %b", i, wr_ready, exp_ready); end
      vectors++;
      if (ram_we !== 1'b1 || ram_addr !== f[i].a || ram_wdata !== f[i].d) begin
        miscompares++;
        $display("FAIL drain_write[%0d]: got we=%b %h/%h want we=1 %h/%h", i, ram_we, ram_addr, ram_wdata, f[i].a, f[i].d);
      end
      if (wr_valid && exp_ready) occ++;
      occ--;
      step();
      if (occ >= 0 && exp_ready) wr_valid = 1'b0;
    end
    wr_valid = 1'b0; settle();
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL drain_done: got we=%b want 0", ram_we); end
    step();
  endtask

  // Random reads and writes over 16 addresses; order, backpressure and read data vs. model.
  task automatic test_random_traffic();
    logic [7:0] model [16];
    bit         written [16];
    wr_t        exp_q [$];
    wr_t        head;
    bit         pend_rd;
    logic [7:0] exp_rd;
    int         gap, idx;
    bit         exp_ready;
    for (int j = 0; j < 16; j++) written[j] = 1'b0;
    pend_rd = 1'b0; gap = 8; exp_rd = '0;
    for (int c = 0; c < 400; c++) begin
      rd_en    = (gap >= 8) && ($urandom_range(1) == 1);
      rd_addr  = 10'h200 + 10'($urandom_range(15));
      idx      = $urandom_range(15);
      wr_valid = ($urandom_range(1) == 1);
      wr_addr  = 10'h200 + 10'(idx);
      wr_data  = 8'($urandom);
      settle();
      if (pend_rd) begin
        vectors++; if (rd_data !== exp_rd) begin miscompares++; $display("FAIL rand_read c=%0d: got %h want %h", c, rd_data, exp_rd); end
      end
      exp_ready = (exp_q.size() != 4);
      vectors++; if (wr_ready !== exp_ready) begin miscompares++; $display("FAIL rand_ready c=%0d: got %b want %b", c, wr_ready, exp_ready); end
      if (ram_we === 1'b1) begin
        vectors++;
        if (rd_en || exp_q.size() == 0) begin
          miscompares++; $display("FAIL rand_spurious_write c=%0d: got we=1 want 0", c);
        end else begin
          head = exp_q.pop_front();
          if (ram_addr !== head.a || ram_wdata !== head.d) begin
            miscompares++; $display("FAIL rand_order c=%0d: got %h/%h want %h/%h", c, ram_addr, ram_wdata, head.a, head.d);
          end
        end
      end
      pend_rd = rd_en;
      exp_rd  = mem[rd_addr];
      if (wr_valid && wr_ready) begin
        exp_q.push_back('{a: wr_addr, d: wr_data});
        model[idx] = wr_data; written[idx] = 1'b1;
      end
      gap = rd_en ? 1 : gap + 1;
      step();
    end
    drive_idle();
    for (int c = 0; c < 12; c++) begin
      settle();
      if (pend_rd) begin
        vectors++; if (rd_data !== exp_rd) begin miscompares++; $display("FAIL rand_read_tail: got %h want %h", rd_data, exp_rd); end
        pend_rd = 1'b0;
      end
      if (ram_we === 1'b1 && exp_q.size() != 0) begin
        head = exp_q.pop_front();
        vectors++; if (ram_addr !== head.a || ram_wdata !== head.d) begin miscompares++; $display("FAIL rand_drain: got %h/%h want %h/%h", ram_addr, ram_wdata, head.a, head.d); end
      end
      step();
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_pending: got %0d left want 0", exp_q.size()); end
    for (int j = 0; j < 16; j++) begin
      if (written[j]) begin
        rd_en = 1'b1; rd_addr = 10'h200 + 10'(j); step();
        rd_en = 1'b0; settle();
        vectors++; if (rd_data !== model[j]) begin miscompares++; $display("FAIL rand_readback[%0d]: got %h want %h", j, rd_data, model[j]); end
        step();
      end
    end
  endtask

  // Runs one clear with periodic reads; optional second request at clr_cnt 500.
  // Returns busy and read counts seen while busy; optionally queues 0x3FF=5A mid-clear.
  task automatic run_clear(input bit repulse, input bit queue_write, output int busy, output int reads);
    int  phase, clr;
    bit  pulsed, done;
    phase = $urandom_range(7);
    busy = 0; reads = 0; clr = 0; pulsed = 1'b0; done = 1'b0;
    clear_req = 1'b1; step(); clear_req = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      rd_en   = ((c % 8) == phase);
      rd_addr = 10'($urandom_range(1023));
      clear_req = repulse && !pulsed && clear_busy && (clr == 500) && !rd_en;
      if (clear_req) pulsed = 1'b1;
      wr_valid = queue_write && (c == 600);
      wr_addr  = 10'h3FF; wr_data = 8'h5A;
      settle();
      if (clear_busy === 1'b1) begin
        busy++;
        if (rd_en) reads++; else clr++;
      end else begin
        done = 1'b1;
      end
      step();
    end
    drive_idle();
    vectors++; if (!done) begin miscompares++; $display("FAIL clear_timeout: got busy after 3000 cycles want idle"); end
    for (int c = 0; c < 4; c++) step();
  endtask

  // T4: clear under read traffic; a write queued mid-clear survives it.
  task automatic test_clear();
    int busy, reads;
    logic [7:0] exp;
    run_clear(1'b0, 1'b1, busy, reads);
    vectors++; if (busy != 1024 + reads) begin miscompares++; $display("FAIL clear_duration: got %0d want %0d", busy, 1024 + reads); end
    for (int a = 0; a <= 1024; a++) begin
      rd_en = (a < 1024); rd_addr = 10'(a);
      settle();
      if (a > 0) begin
        exp = (a - 1 == 1023) ? 8'h5A : 8'h00;
        vectors++; if (rd_data !== exp) begin miscompares++; $display("FAIL clear_readback[%0d]: got %h want %h", a - 1, rd_data, exp); end
      end
      step();
    end
    drive_idle(); step();
  endtask

  // T5: a second request mid-clear does not restart the sequence.
  task automatic test_clear_restart();
    int busy, reads;
    run_clear(1'b1, 1'b0, busy, reads);
    vectors++; if (busy != 1024 + reads) begin miscompares++; $display("FAIL clear_no_restart: got %0d want %0d", busy, 1024 + reads); end
  endtask

  // T6: reset mid-clear with a full write buffer.
  task automatic test_reset_mid_clear();
    int  clr, we_base;
    bit  hit;
    wr_valid = 1'b1; wr_addr = 10'h3FF; wr_data = 8'h5A; step();
    wr_valid = 1'b0; step();
    rd_en = 1'b1; rd_addr = 10'h3FF; step();
    rd_en = 1'b0; step();
    clear_req = 1'b1; step(); clear_req = 1'b0;
    clr = 0; hit = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      wr_valid = (clr >= 296 && clr < 300);
      wr_addr = 10'($urandom_range(1023)); wr_data = 8'($urandom);
      settle();
      if (clr == 300) hit = 1'b1;
      else begin
        if (clear_busy === 1'b1) clr++;
        step();
      end
    end
    vectors++; if (!hit || wr_ready !== 1'b0 || rd_data !== 8'h5A) begin miscompares++; $display("FAIL pre_reset: got hit=%b ready=%b rd=%h want hit=1 ready=0 rd=5a", hit, wr_ready, rd_data); end
    reset_n = 1'b0; #1;
    vectors++; if (clear_busy !== 1'b0) begin miscompares++; $display("FAIL rst_clear_busy: got %b want 0", clear_busy); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
    step(); step();
    @(negedge clk); reset_n = 1'b1;
    we_base = we_count;
    for (int c = 0; c < 20; c++) step();
    vectors++; if (we_count - we_base != 0) begin miscompares++; $display("FAIL post_reset_writes: got %0d want 0", we_count - we_base); end
    vectors++; if (clear_busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy: got %b want 0", clear_busy); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_read_priority();
    test_fifo_full();
    test_random_traffic();
    test_clear();
    test_clear_restart();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
